// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, trap causes,
// result-select encodings, CSR addresses and the trap-cause priority helper.
package wb_pkg;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_TVAL  = 3'd3,
    S_T_REDIR = 3'd4
  } wb_state_e;

  localparam logic [3:0] CAUSE_LAM   = 4'd4;
  localparam logic [3:0] CAUSE_LAF   = 4'd5;
  localparam logic [3:0] CAUSE_SAM   = 4'd6;
  localparam logic [3:0] CAUSE_SAF   = 4'd7;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;

  localparam logic [1:0] RES_ALU   = 2'd0;
  localparam logic [1:0] RES_MEM   = 2'd1;
  localparam logic [1:0] RES_NPC   = 2'd2;
  localparam logic [1:0] RES_CSRFD = 2'd3;

  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // Highest-priority cause among the simultaneously raised exception flags.
  function automatic logic [3:0] trap_cause(input logic ecall, input logic sam,
                                            input logic lam, input logic saf,
                                            input logic laf);
    logic [3:0] cause;
    if (ecall)    cause = CAUSE_ECALL;
    else if (sam) cause = CAUSE_SAM;
    else if (lam) cause = CAUSE_LAM;
    else if (saf) cause = CAUSE_SAF;
    else if (laf) cause = CAUSE_LAF;
    else          cause = CAUSE_LAF;
    return cause;
  endfunction

endpackage

// File: rtl/wb_trap_fsm.sv
// Trap sequencer: owns the stage state, the CSR write port (normal retires and the
// mepc/mcause/mtval trap writes) and the one-cycle redirect to mtvec.
module wb_trap_fsm #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_v,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic            wb_csr_we,
  input  logic [11:0]     wb_csr_addr,
  input  logic [XLEN-1:0] wb_csr_wdata,
  input  logic            wb_ecall,
  input  logic            mem_lam,
  input  logic            mem_laf,
  input  logic            mem_sam,
  input  logic            mem_saf,
  input  logic [XLEN-1:0] mtvec,
  output logic            retire,
  output logic            wb_stall,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_data,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_pc,
  output logic            flush
);
  import wb_pkg::*;

  wb_state_e       state_r;
  logic [3:0]      cause_r;
  logic [XLEN-1:0] tval_r;
  logic            fault_s;

  assign fault_s  = wb_ecall | mem_lam | mem_laf | mem_sam | mem_saf;
  assign wb_stall = (state_r != S_RUN);
  assign retire   = (state_r == S_RUN) && wb_v && !fault_s;

  // State register plus registered CSR and redirect ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_RUN;
      cause_r       <= 4'd0;
      tval_r        <= '0;
      csr_we        <= 1'b0;
      csr_addr      <= 12'd0;
      csr_data      <= '0;
      trap_redirect <= 1'b0;
      trap_pc       <= '0;
      flush         <= 1'b0;
    end else begin
      case (state_r)
        S_RUN: begin
          trap_redirect <= 1'b0;
          flush         <= 1'b0;
          if (wb_v && fault_s) begin
            // The mepc write goes out on the same edge the fault is sampled.
            csr_we   <= 1'b1;
            csr_addr <= CSR_MEPC;
            csr_data <= wb_pc;
            cause_r  <= trap_cause(wb_ecall, mem_sam, mem_lam, mem_saf, mem_laf);
            tval_r   <= wb_ecall ? '0 : wb_alu_result;
            state_r  <= S_T_EPC;
          end else if (retire && wb_csr_we) begin
            csr_we   <= 1'b1;
            csr_addr <= wb_csr_addr;
            csr_data <= wb_csr_wdata;
          end else begin
            csr_we <= 1'b0;
          end
        end
        S_T_EPC: begin
          csr_we   <= 1'b1;
          csr_addr <= CSR_MCAUSE;
          csr_data <= {{(XLEN-4){1'b0}}, cause_r};
          state_r  <= S_T_CAUSE;
        end
        S_T_CAUSE: begin
          csr_we   <= 1'b1;
          csr_addr <= CSR_MTVAL;
          csr_data <= tval_r;
          state_r  <= S_T_TVAL;
        end
        S_T_TVAL: begin
          csr_we        <= 1'b0;
          trap_redirect <= 1'b1;
          flush         <= 1'b1;
          trap_pc       <= mtvec & ~{{(XLEN-2){1'b0}}, 2'b11};
          state_r       <= S_T_REDIR;
        end
        S_T_REDIR: begin
          csr_we        <= 1'b0;
          trap_redirect <= 1'b0;
          flush         <= 1'b0;
          state_r       <= S_RUN;
        end
        default: begin
          csr_we        <= 1'b0;
          trap_redirect <= 1'b0;
          flush         <= 1'b0;
          state_r       <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// RV64 writeback stage: result mux, registered RF write port, trap sequencer and
// the retired-instruction counter (present only when WB_INSTRET_EN is defined).
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_v,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_npc,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_mem_result,
  input  logic [XLEN-1:0] wb_csrfd,
  input  logic [XLEN-1:0] wb_csr_wdata,
  input  logic [1:0]      wb_res_sel,
  input  logic            wb_reg_we,
  input  logic [4:0]      wb_drid,
  input  logic            wb_csr_we,
  input  logic [11:0]     wb_csr_addr,
  input  logic            wb_ecall,
  input  logic            mem_lam,
  input  logic            mem_laf,
  input  logic            mem_sam,
  input  logic            mem_saf,
  input  logic [XLEN-1:0] mtvec,
  output logic            rf_we,
  output logic [4:0]      rf_dr,
  output logic [XLEN-1:0] rf_data,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_data,
  output logic            wb_stall,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_pc,
  output logic            flush,
  output logic [XLEN-1:0] instret
);
  import wb_pkg::*;

  logic            retire_s;
  logic            rf_wr_s;
  logic [XLEN-1:0] result_s;

  wb_trap_fsm #(.XLEN(XLEN)) u_trap_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_v          (wb_v),
    .wb_pc         (wb_pc),
    .wb_alu_result (wb_alu_result),
    .wb_csr_we     (wb_csr_we),
    .wb_csr_addr   (wb_csr_addr),
    .wb_csr_wdata  (wb_csr_wdata),
    .wb_ecall      (wb_ecall),
    .mem_lam       (mem_lam),
    .mem_laf       (mem_laf),
    .mem_sam       (mem_sam),
    .mem_saf       (mem_saf),
    .mtvec         (mtvec),
    .retire        (retire_s),
    .wb_stall      (wb_stall),
    .csr_we        (csr_we),
    .csr_addr      (csr_addr),
    .csr_data      (csr_data),
    .trap_redirect (trap_redirect),
    .trap_pc       (trap_pc),
    .flush         (flush)
  );

  // Result select for the rd write.
  always_comb begin
    result_s = wb_alu_result;
    case (wb_res_sel)
      RES_ALU:   result_s = wb_alu_result;
      RES_MEM:   result_s = wb_mem_result;
      RES_NPC:   result_s = wb_npc;
      RES_CSRFD: result_s = wb_csrfd;
      default:   result_s = wb_alu_result;
    endcase
  end

  assign rf_wr_s = retire_s && wb_reg_we && (wb_drid != 5'd0);

  // Registered RF write port; index and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_dr   <= 5'd0;
      rf_data <= '0;
    end else begin
      rf_we <= rf_wr_s;
      if (rf_wr_s) begin
        rf_dr   <= wb_drid;
        rf_data <= result_s;
      end else begin
        rf_dr   <= rf_dr;
        rf_data <= rf_data;
      end
    end
  end

`ifdef WB_INSTRET_EN
  logic [XLEN-1:0] instret_r;

  // Retire counter; a retiring minstret write overrides that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (retire_s && wb_csr_we && (wb_csr_addr == CSR_MINSTRET)) begin
      instret_r <= wb_csr_wdata;
    end else if (retire_s) begin
      instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret = instret_r;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a per-cycle expectation scoreboard.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_v;
  logic [63:0] wb_pc, wb_npc, wb_alu_result, wb_mem_result, wb_csrfd, wb_csr_wdata;
  logic [1:0]  wb_res_sel;
  logic        wb_reg_we;
  logic [4:0]  wb_drid;
  logic        wb_csr_we;
  logic [11:0] wb_csr_addr;
  logic        wb_ecall, mem_lam, mem_laf, mem_sam, mem_saf;
  logic [63:0] mtvec;
  logic        rf_we, csr_we, wb_stall, trap_redirect, flush;
  logic [4:0]  rf_dr;
  logic [63:0] rf_data, csr_data, trap_pc, instret;
  logic [11:0] csr_addr;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .wb_v(wb_v), .wb_pc(wb_pc), .wb_npc(wb_npc),
    .wb_alu_result(wb_alu_result), .wb_mem_result(wb_mem_result), .wb_csrfd(wb_csrfd),
    .wb_csr_wdata(wb_csr_wdata), .wb_res_sel(wb_res_sel), .wb_reg_we(wb_reg_we),
    .wb_drid(wb_drid), .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr),
    .wb_ecall(wb_ecall), .mem_lam(mem_lam), .mem_laf(mem_laf), .mem_sam(mem_sam),
    .mem_saf(mem_saf), .mtvec(mtvec), .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_data(csr_data), .wb_stall(wb_stall),
    .trap_redirect(trap_redirect), .trap_pc(trap_pc), .flush(flush), .instret(instret)
  );

  typedef struct {
    logic        rf_we;
    logic [4:0]  rf_dr;
    logic [63:0] rf_data;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_data;
    logic        redirect;
    logic        flush;
    logic [63:0] trap_pc;
    logic        stall;
    logic [63:0] instret;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m;
  int          m_trap;
  logic [63:0] m_cause, m_tval;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.rf_we = 1'b0; m.rf_dr = 5'd0; m.rf_data = 64'd0;
    m.csr_we = 1'b0; m.csr_addr = 12'd0; m.csr_data = 64'd0;
    m.redirect = 1'b0; m.flush = 1'b0; m.trap_pc = 64'd0;
    m.stall = 1'b0; m.instret = 64'd0;
    m_trap = 0; m_cause = 64'd0; m_tval = 64'd0;
  endtask

  task automatic idle_inputs();
    wb_v = 1'b0; wb_pc = 64'd0; wb_npc = 64'd0; wb_alu_result = 64'd0;
    wb_mem_result = 64'd0; wb_csrfd = 64'd0; wb_csr_wdata = 64'd0;
    wb_res_sel = 2'd0; wb_reg_we = 1'b0; wb_drid = 5'd0; wb_csr_we = 1'b0;
    wb_csr_addr = 12'd0; wb_ecall = 1'b0; mem_lam = 1'b0; mem_laf = 1'b0;
    mem_sam = 1'b0; mem_saf = 1'b0; mtvec = 64'd0;
  endtask

  // Predict the outputs after the next rising edge from the inputs now driven.
  task automatic predict();
    logic fault;
    fault = wb_ecall | mem_lam | mem_laf | mem_sam | mem_saf;
    case (m_trap)
      0: begin
        m.redirect = 1'b0; m.flush = 1'b0;
        if (wb_v && fault) begin
          m.rf_we = 1'b0;
          m.csr_we = 1'b1; m.csr_addr = 12'h341; m.csr_data = wb_pc;
          m_cause = wb_ecall ? 64'd11 : mem_sam ? 64'd6 : mem_lam ? 64'd4 : mem_saf ? 64'd7 : 64'd5;
          m_tval = wb_ecall ? 64'd0 : wb_alu_result;
          m_trap = 1;
        end else if (wb_v) begin
          m.rf_we = wb_reg_we && (wb_drid != 5'd0);
          if (m.rf_we) begin
            m.rf_dr = wb_drid;
            m.rf_data = (wb_res_sel == 2'd0) ? wb_alu_result :
                        (wb_res_sel == 2'd1) ? wb_mem_result :
                        (wb_res_sel == 2'd2) ? wb_npc : wb_csrfd;
          end
          m.csr_we = wb_csr_we;
          if (wb_csr_we) begin m.csr_addr = wb_csr_addr; m.csr_data = wb_csr_wdata; end
`ifdef WB_INSTRET_EN
          if (wb_csr_we && wb_csr_addr == 12'hB02) m.instret = wb_csr_wdata;
          else m.instret = m.instret + 64'd1;
`endif
        end else begin
          m.rf_we = 1'b0; m.csr_we = 1'b0;
        end
      end
      1: begin m.rf_we = 1'b0; m.csr_we = 1'b1; m.csr_addr = 12'h342; m.csr_data = m_cause; m_trap = 2; end
      2: begin m.rf_we = 1'b0; m.csr_we = 1'b1; m.csr_addr = 12'h343; m.csr_data = m_tval; m_trap = 3; end
      3: begin
        m.rf_we = 1'b0; m.csr_we = 1'b0; m.redirect = 1'b1; m.flush = 1'b1;
        m.trap_pc = {mtvec[63:2], 2'b00}; m_trap = 4;
      end
      default: begin m.rf_we = 1'b0; m.csr_we = 1'b0; m.redirect = 1'b0; m.flush = 1'b0; m_trap = 0; end
    endcase
    m.stall = (m_trap != 0);
    sb_q.push_back(m);
  endtask

  task automatic step(input string tag);
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, e.rf_we});
    chk({tag, ".rf_dr"}, {59'd0, rf_dr}, {59'd0, e.rf_dr});
    chk({tag, ".rf_data"}, rf_data, e.rf_data);
    chk({tag, ".csr_we"}, {63'd0, csr_we}, {63'd0, e.csr_we});
    chk({tag, ".csr_addr"}, {52'd0, csr_addr}, {52'd0, e.csr_addr});
    chk({tag, ".csr_data"}, csr_data, e.csr_data);
    chk({tag, ".redirect"}, {63'd0, trap_redirect}, {63'd0, e.redirect});
    chk({tag, ".flush"}, {63'd0, flush}, {63'd0, e.flush});
    chk({tag, ".trap_pc"}, trap_pc, e.trap_pc);
    chk({tag, ".stall"}, {63'd0, wb_stall}, {63'd0, e.stall});
    chk({tag, ".instret"}, instret, e.instret);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rf_we"}, {63'd0, rf_we}, 64'd0);
    chk({tag, ".rf_dr"}, {59'd0, rf_dr}, 64'd0);
    chk({tag, ".rf_data"}, rf_data, 64'd0);
    chk({tag, ".csr_we"}, {63'd0, csr_we}, 64'd0);
    chk({tag, ".csr_addr"}, {52'd0, csr_addr}, 64'd0);
    chk({tag, ".csr_data"}, csr_data, 64'd0);
    chk({tag, ".redirect"}, {63'd0, trap_redirect}, 64'd0);
    chk({tag, ".flush"}, {63'd0, flush}, 64'd0);
    chk({tag, ".trap_pc"}, trap_pc, 64'd0);
    chk({tag, ".stall"}, {63'd0, wb_stall}, 64'd0);
    chk({tag, ".instret"}, instret, 64'd0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step("idle");

    // ALU retire to x5
    wb_v = 1'b1; wb_reg_we = 1'b1; wb_drid = 5'd5; wb_res_sel = 2'd0; wb_alu_result = 64'h1234;
    step("alu_retire");
    // x0 write suppressed, still retires
    wb_drid = 5'd0; wb_alu_result = 64'h5555;
    step("x0_suppress");
    // Back-to-back: MEM, NPC, CSRFD results plus a CSR write
    wb_drid = 5'd7; wb_res_sel = 2'd1; wb_mem_result = 64'hDEAD_BEEF_0000_0001;
    step("mem_result");
    wb_drid = 5'd8; wb_res_sel = 2'd2; wb_npc = 64'h8000_0204;
    step("npc_result");
    wb_drid = 5'd31; wb_res_sel = 2'd3; wb_csrfd = 64'hA5A5_0000_1111_2222;
    wb_csr_we = 1'b1; wb_csr_addr = 12'h300; wb_csr_wdata = 64'h0000_0000_0000_1888;
    step("csr_retire");
    wb_v = 1'b0; wb_csr_we = 1'b0;
    step("bubble");

    // Load misaligned trap; valid instructions held during the sequence are ignored
    wb_v = 1'b1; mem_lam = 1'b1; wb_pc = 64'h8000_0100; wb_alu_result = 64'h1003;
    wb_reg_we = 1'b1; wb_drid = 5'd9; wb_res_sel = 2'd0; mtvec = 64'h8000_0001;
    step("lam_epc");
    mem_lam = 1'b0; wb_alu_result = 64'h7777;
    step("lam_cause");
    step("lam_tval");
    step("lam_redir");
    step("lam_return");
    step("after_trap_retire");

    // ECALL and SAF together: ECALL wins with tval 0
    wb_ecall = 1'b1; mem_saf = 1'b1; wb_pc = 64'h8000_0200; wb_alu_result = 64'hFFFF_0000;
    mtvec = 64'h0000_0000_9000_0002;
    step("ecall_epc");
    wb_v = 1'b0; wb_ecall = 1'b0; mem_saf = 1'b0;
    step("ecall_cause");
    step("ecall_tval");
    step("ecall_redir");
    step("ecall_return");

    // SAM beats LAM and LAF
    wb_v = 1'b1; mem_sam = 1'b1; mem_lam = 1'b1; mem_laf = 1'b1;
    wb_pc = 64'h8000_0300; wb_alu_result = 64'h2002; mtvec = 64'h8000_0003;
    step("sam_epc");
    wb_v = 1'b0; mem_sam = 1'b0; mem_lam = 1'b0; mem_laf = 1'b0;
    step("sam_cause");
    step("sam_tval");
    step("sam_redir");
    step("sam_return");

    // Reset asserted while in T_CAUSE
    wb_v = 1'b1; mem_laf = 1'b1; wb_pc = 64'h8000_0400; wb_alu_result = 64'h3000;
    step("rst_epc");
    wb_v = 1'b0; mem_laf = 1'b0;
    step("rst_cause");
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_trap_reset");
    model_reset();
    rst_n = 1'b1;
    step("post_reset_1");
    step("post_reset_2");
    step("post_reset_3");

    // minstret preload and wrap, then same-cycle write of 7
    wb_v = 1'b1; wb_reg_we = 1'b0; wb_csr_we = 1'b1; wb_csr_addr = 12'hB02;
    wb_csr_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step("instret_preload");
    wb_csr_we = 1'b0; wb_reg_we = 1'b1; wb_drid = 5'd1; wb_alu_result = 64'h42;
    step("instret_wrap");
    wb_csr_we = 1'b1; wb_csr_wdata = 64'd7;
    step("instret_write7");
    wb_csr_we = 1'b0;
    step("instret_after");
    idle_inputs();
    step("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
